// File: rtl/limn2600_bus_pkg.sv
// Shared definitions for Limn2600 memory-bus initiators: FSM state type and common
// bus constants.
package limn2600_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } bus_state_e;

  localparam int unsigned DefaultTimeout = 256;

  // Serial emulation port, shared with the other initiators that poll it.
  localparam logic [31:0] SerialEmuAddr = 32'hF8000040;

endpackage

// File: rtl/limn2600_mem_initiator.sv
// Single-outstanding load/store initiator for the Limn2600 cs/we/addr/data/rdy bus,
// with misalignment rejection and a rdy timeout so a silent responder cannot hang the core.
module limn2600_mem_initiator
  import limn2600_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              cs,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rdy
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  bus_state_e state_q;
  logic [CntW-1:0] cnt_q;

  // A responder may still present rdy from the previous select; hold off until it drops.
  assign req_ready = (state_q == StIdle) && !rdy && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cs         <= 1'b0;
      we         <= 1'b0;
      addr       <= '0;
      data_out   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            if (req_addr[1:0] != 2'b00) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state_q    <= StResp;
            end else begin
              cs       <= 1'b1;
              we       <= req_we;
              addr     <= req_addr;
              data_out <= req_wdata;
              cnt_q    <= '0;
              state_q  <= StAccess;
            end
          end
        end
        StAccess: begin
          // rdy takes priority over an expiring timeout in the same cycle.
          if (rdy) begin
            cs         <= 1'b0;
            we         <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we ? '0 : data_in;
            state_q    <= StResp;
          end else if (cnt_q == CntMax) begin
            cs         <= 1'b0;
            we         <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            state_q    <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_limn2600_mem_initiator.sv
// Bench for limn2600_mem_initiator against a registered-rdy SRAM model; responses are
// checked through an expected-response queue.
module tb_limn2600_mem_initiator;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        cs, we;
  logic [31:0] addr, data_out, data_in;
  logic        rdy;
  logic        mute;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  limn2600_mem_initiator #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .cs        (cs),
    .we        (we),
    .addr      (addr),
    .data_out  (data_out),
    .data_in   (data_in),
    .rdy       (rdy)
  );

  // Responder: rdy follows cs one edge later; mute models an absent device.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy <= 1'b0;
    else     rdy <= cs && !mute;
  end

  always @(posedge clk) begin
    if (cs) begin
      if (we) mem[addr[9:2]] <= data_out;
      else    data_in <= mem[addr[9:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic e_err, input logic [31:0] e_rdata,
                         input int e_lat, input int e_cs, input int hold);
    int    lat, cs_cyc, guard;
    resp_t r;
    exp_q.push_back('{err: e_err, rdata: e_rdata});
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept", 64'(guard < 50), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; cs_cyc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (cs) cs_cyc++;
    end while (!resp_valid && lat < 100);
    check("latency", 64'(lat), 64'(e_lat));
    check("cs_cycles", 64'(cs_cyc), 64'(e_cs));
    r = exp_q.pop_front();
    check("rdata", 64'(resp_rdata), 64'(r.rdata));
    check("err", 64'(resp_err), 64'(r.err));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_rdata", 64'(resp_rdata), 64'(r.rdata));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("valid_clear", 64'(resp_valid), 64'd0);
    check("cs_idle", 64'(cs), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t r;
    int    rises, accepts, prev_acc;
    logic  cs_prev;
    rst = 1'b1; mute = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cs", 64'(cs), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 64'(req_ready), 64'd1);

    // Store then load back.
    run_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 3, 2, 0);
    run_req(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 2, 0);
    run_req(1'b1, 32'h24, 32'h12345678, 1'b0, 32'h0, 3, 2, 0);
    // Misaligned load: error right after accept, no bus cycle.
    run_req(1'b0, 32'h2, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    // Slow consumer: response must stay put.
    run_req(1'b0, 32'h24, 32'h0, 1'b0, 32'h12345678, 3, 2, 5);
    // Missing responder: timeout after TO cycles of cs.
    mute = 1'b1;
    run_req(1'b0, 32'h100, 32'h0, 1'b1, 32'h0, TO + 1, TO, 0);
    mute = 1'b0;

    // Back-to-back loads with req_valid held.
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    rises = 0; accepts = 0; prev_acc = -1; cs_prev = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (cs && !cs_prev) rises++;
      cs_prev = cs;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          r = exp_q.pop_front();
          check("b2b_rdata", 64'(resp_rdata), 64'(r.rdata));
          check("b2b_err", 64'(resp_err), 64'(r.err));
        end
      end
      if (req_ready) begin
        exp_q.push_back('{err: 1'b0, rdata: 32'hDEADBEEF});
        check("b2b_ready_rdy", 64'(rdy), 64'd0);
        if (prev_acc >= 0) check("b2b_gap", 64'(c - prev_acc), 64'd4);
        prev_acc = c;
        accepts++;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cs && !cs_prev) rises++;
      cs_prev = cs;
      if (resp_valid && exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check("b2b_drain_rdata", 64'(resp_rdata), 64'(r.rdata));
      end
    end
    check("b2b_cs_per_req", 64'(rises), 64'(accepts));
    check("b2b_accepts", 64'(accepts), 64'd6);
    check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
    resp_ready = 1'b0;

    // Reset during an access.
    mute = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_cs", 64'(cs), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_cs", 64'(cs), 64'd0);
    check("async_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("async_rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0; mute = 1'b0;
    @(negedge clk);
    check("post_rst_cs", 64'(cs), 64'd0);
    run_req(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/limn2600_mem_initiator.md
Name: limn2600_mem_initiator

Overview:
Bus initiator for the Limn2600 single-cycle-select memory interface (cs/we/addr/data/rdy). Accepts one load/store request at a time from the CPU memory stage over a valid/ready channel, drives the memory-side strobes, waits for rdy, and returns read data or an error on a response channel. Adds a rdy timeout and an alignment check so a missing or unmapped responder cannot hang the core.

Parameters:
ADDR_W, 32, request/bus address width
DATA_W, 32, data width
TIMEOUT, 256, max cycles in ACCESS without rdy before error (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  CPU request valid
req_ready  out  1  request accepted when valid&&ready at posedge
req_we  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address, must be word aligned
req_wdata  in  DATA_W  store data
resp_valid  out  1  response valid, held until resp_ready
resp_ready  in  1  CPU consumes response
resp_rdata  out  DATA_W  load data (0 on store or error)
resp_err  out  1  1=misaligned or timeout
cs  out  1  memory chip select
we  out  1  memory write enable
addr  out  ADDR_W  memory address
data_out  out  DATA_W  write data to memory
data_in  in  DATA_W  read data from memory
rdy  in  1  memory ready

Behaviour:
- One clock; reset asynchronous, active-high. On rst all outputs 0, state IDLE, counter 0; a reset mid-access drops cs immediately and discards the transfer.
- All outputs registered except req_ready = (state==IDLE) && !rdy; the !rdy term blocks a new access while the responder still shows stale rdy from the prior select.
- States: IDLE, ACCESS, RESP.
- IDLE: on req_valid&&req_ready:
  - If req_addr[1:0]!=0: go RESP with resp_err=1, resp_rdata=0; cs never asserted.
  - Else: latch we/addr/data_out from request, cs<=1, counter<=0, go ACCESS.
- ACCESS: cs, we, addr, data_out held stable.
  - rdy==1: cs<=0, we<=0; resp_rdata<=(we?0:data_in); resp_err<=0; go RESP.
  - rdy==0 && counter==TIMEOUT-1: cs<=0, we<=0, resp_rdata<=0, resp_err<=1, go RESP.
  - Otherwise counter++.
  - rdy and timeout in the same cycle: rdy wins (no error).
- RESP: resp_valid=1 with stable rdata/err. On resp_ready go IDLE, resp_valid<=0 next cycle.
- Latency against a responder that registers rdy one edge after cs: request accepted at edge E0; cs high after E0; rdy high after E1; resp_valid high after E2. Next request accepts no earlier than the first cycle rdy reads 0.
- Counter width: $clog2(TIMEOUT). No wrap: the counter saturates by leaving ACCESS.
- addr passed unmodified (byte address). The responder does the word indexing.

Decomposition:
- Shared package limn2600_bus_pkg: state enum (IDLE/ACCESS/RESP), default TIMEOUT constant, and the serial-emulation address constant 32'hF8000040 for use by other initiators.
- No sub-module needed. Optional small limn2600_timeout_ctr holding the clear/increment/expired counter.

Test Plan:
- Store 0xDEADBEEF to 0x00000010, then load 0x00000010 against the SRAM model -> store resp err=0 rdata=0; load resp rdata=0xDEADBEEF, resp_valid 2 cycles after accept edge, cs high exactly 2 cycles per access.
- Load 0x00000002 -> resp_err=1, resp_rdata=0 one cycle after accept, cs never high.
- TIMEOUT=16, rdy tied 0, load 0x00000100 -> cs high 16 cycles, then resp_err=1, cs=0.
- resp_ready held 0 for 5 cycles after a load -> resp_valid/rdata stable throughout; req_ready=0 until consumed and rdy=0.
- Back-to-back loads with req_valid held high -> second accept only after rdy drops; no double cs pulse per request.
- Assert rst during ACCESS -> cs, resp_valid, req_ready low asynchronously; after release, a fresh load of 0x00000010 completes normally.
